// File: rtl/joypad_pkg.sv
// Shared definitions for the joypad port models: button order, turbo bit map, shared types.
package joypad_pkg;

    localparam int JOY_BITS = 8;
    localparam int CNT_W    = 4;

    // Report order of a stock pad; bit 0 is returned first after a load.
    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    localparam int TURBO_A = 0;
    localparam int TURBO_B = 1;

    typedef enum logic [1:0] {
        ACT_HOLD  = 2'd0,
        ACT_LOAD  = 2'd1,
        ACT_SHIFT = 2'd2
    } sr_action_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value,
                                                 input logic [CNT_W-1:0] limit);
        return (value >= limit) ? limit : value + CNT_W'(1);
    endfunction

endpackage

// File: rtl/pin_sync.sv
// Multi-bit flop-chain synchronizer for slow, independently toggling pins.
module pin_sync #(
    parameter int               WIDTH     = 1,
    parameter int               STAGES    = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] chain [STAGES];

    // NOTE: the chain is a handful of flops, not a RAM, so every stage is
    // reset; the reset value sets how the pin looks before the first sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) chain[i] <= RESET_VAL;
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/joypad_responder.sv
// Controller-side model of a 4021-style pad: synchronized load/shift of the
// button report onto an active-low serial line, with optional A/B auto-fire.
module joypad_responder
    import joypad_pkg::*;
#(
    parameter int NUM_BITS    = JOY_BITS,
    parameter int SYNC_STAGES = 2,
    parameter int TURBO_DIV   = 16
) (
    input  logic                CLK,
    input  logic                n_RES,
    input  logic                strobe,
    input  logic                n_in,
    input  logic [NUM_BITS-1:0] buttons,
    input  logic [1:0]          turbo_en,
    output logic                ser_n,
    output logic [CNT_W-1:0]    bits_read,
    output logic                overread
);

    localparam int TC_W = (TURBO_DIV > 1) ? $clog2(TURBO_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(NUM_BITS);
    localparam logic [TC_W-1:0]  TC_LAST  = TC_W'(TURBO_DIV - 1);

    logic                strobe_s;
    logic                strobe_d;
    logic                n_in_s;
    logic                n_in_d;
    logic [NUM_BITS-1:0] buttons_s;

    logic [NUM_BITS-1:0] sr;
    logic [CNT_W-1:0]    cnt;
    logic [TC_W-1:0]     turbo_cnt;
    logic                turbo_ph;

    logic                shift_ev;
    logic                strobe_rise;
    logic [NUM_BITS-1:0] bm;
    sr_action_e          action;

    pin_sync #(.WIDTH(1), .STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_strobe (
        .clk   (CLK),
        .rst_n (n_RES),
        .d     (strobe),
        .q     (strobe_s)
    );

    // Idle level of n_in is high; resetting its chain high keeps the first
    // post-reset sample from looking like the end of a read pulse.
    pin_sync #(.WIDTH(1), .STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_n_in (
        .clk   (CLK),
        .rst_n (n_RES),
        .d     (n_in),
        .q     (n_in_s)
    );

    pin_sync #(.WIDTH(NUM_BITS), .STAGES(SYNC_STAGES), .RESET_VAL('0)) u_sync_buttons (
        .clk   (CLK),
        .rst_n (n_RES),
        .d     (buttons),
        .q     (buttons_s)
    );

    assign shift_ev    = n_in_s & ~n_in_d;
    assign strobe_rise = strobe_s & ~strobe_d;

    // NOTE: every signal driven here gets its default first, so no path
    // through the block can leave a value held and infer a latch.
    always_comb begin
        bm     = buttons_s;
        action = ACT_HOLD;
        bm[BTN_A] = buttons_s[BTN_A] & ~(turbo_en[TURBO_A] & turbo_ph);
        bm[BTN_B] = buttons_s[BTN_B] & ~(turbo_en[TURBO_B] & turbo_ph);
        if (strobe_s) begin
            action = ACT_LOAD;
        end else if (shift_ev) begin
            action = ACT_SHIFT;
        end
    end

    always_ff @(posedge CLK or negedge n_RES) begin
        if (!n_RES) begin
            n_in_d   <= 1'b1;
            strobe_d <= 1'b0;
            sr       <= '0;
            cnt      <= '0;
        end else begin
            n_in_d   <= n_in_s;
            strobe_d <= strobe_s;
            unique case (action)
                ACT_LOAD: begin
                    sr  <= bm;
                    cnt <= '0;
                end
                // Fill with 1s so reads past the report return "pressed", as a stock pad does.
                ACT_SHIFT: begin
                    sr  <= {1'b1, sr[NUM_BITS-1:1]};
                    cnt <= sat_inc(cnt, CNT_MAX);
                end
                default: begin
                    sr  <= sr;
                    cnt <= cnt;
                end
            endcase
        end
    end

    // Auto-fire phase advances per strobe, independent of whether turbo is enabled.
    always_ff @(posedge CLK or negedge n_RES) begin
        if (!n_RES) begin
            turbo_cnt <= '0;
            turbo_ph  <= 1'b0;
        end else if (strobe_rise) begin
            if (turbo_cnt == TC_LAST) begin
                turbo_cnt <= '0;
                turbo_ph  <= ~turbo_ph;
            end else begin
                turbo_cnt <= turbo_cnt + TC_W'(1);
            end
        end
    end

    assign ser_n     = ~sr[0];
    assign bits_read = cnt;
    assign overread  = (cnt == CNT_MAX);

endmodule

// File: tb/tb_joypad_responder.sv
// Directed bench for joypad_responder: report readout, over-read, live load,
// load/shift collision, async reset mid-report and turbo phase sequence.
module tb_joypad_responder;

    logic       clk;
    logic       n_res;
    logic       strobe;
    logic       n_in;
    logic [7:0] buttons;
    logic [1:0] turbo_en;
    logic       ser_n;
    logic [3:0] bits_read;
    logic       overread;

    int n_tests;
    int n_fail;

    joypad_responder #(
        .NUM_BITS    (8),
        .SYNC_STAGES (2),
        .TURBO_DIV   (2)
    ) dut (
        .CLK       (clk),
        .n_RES     (n_res),
        .strobe    (strobe),
        .n_in      (n_in),
        .buttons   (buttons),
        .turbo_en  (turbo_en),
        .ser_n     (ser_n),
        .bits_read (bits_read),
        .overread  (overread)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] actual, input logic [7:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_pulse();
        strobe = 1'b1;
        tick(4);
        strobe = 1'b0;
        tick(5);
    endtask

    task automatic read_pulse();
        n_in = 1'b0;
        tick(3);
        n_in = 1'b1;
        tick(5);
    endtask

    // ser_n for a report of 8'b0000_1001 (A, START), bit 0 first.
    logic [7:0] exp_ser_t1;
    // Turbo A, TURBO_DIV=2, after 3 priming frames: pressed pattern per frame.
    logic [7:0] exp_turbo;

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        exp_ser_t1 = 8'b1111_0110;
        exp_turbo  = 8'b0011_0011;

        n_res    = 1'b0;
        strobe   = 1'b0;
        n_in     = 1'b1;
        buttons  = 8'h00;
        turbo_en = 2'b00;
        tick(3);
        check("rst_ser_n", {7'd0, ser_n}, 8'd1);
        check("rst_bits_read", {4'd0, bits_read}, 8'd0);
        check("rst_overread", {7'd0, overread}, 8'd0);
        n_res = 1'b1;
        tick(4);
        check("post_rst_bits_read", {4'd0, bits_read}, 8'd0);

        // 1: full report of A+START
        buttons = 8'b0000_1001;
        load_pulse();
        check("t1_bits_after_load", {4'd0, bits_read}, 8'd0);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t1_bit%0d", i), {7'd0, ser_n}, {7'd0, exp_ser_t1[i]});
            read_pulse();
        end
        check("t1_bits_read", {4'd0, bits_read}, 8'd8);
        check("t1_overread", {7'd0, overread}, 8'd1);

        // 2: over-read returns pressed, count saturates
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t2_ser_n%0d", i), {7'd0, ser_n}, 8'd0);
            read_pulse();
            check($sformatf("t2_bits%0d", i), {4'd0, bits_read}, 8'd8);
        end
        check("t2_overread", {7'd0, overread}, 8'd1);

        // 3: strobe held, live A tracking with exact latency, reads ignored
        buttons = 8'h00;
        strobe  = 1'b1;
        tick(5);
        check("t3_bits_cleared", {4'd0, bits_read}, 8'd0);
        check("t3_overread_clr", {7'd0, overread}, 8'd0);
        check("t3_a_released", {7'd0, ser_n}, 8'd1);
        buttons = 8'h01;
        tick(2);
        check("t3_lat_before", {7'd0, ser_n}, 8'd1);
        tick(1);
        check("t3_lat_after", {7'd0, ser_n}, 8'd0);
        buttons = 8'h00;
        tick(3);
        check("t3_a_release_follow", {7'd0, ser_n}, 8'd1);
        read_pulse();
        read_pulse();
        check("t3_no_shift_in_strobe", {4'd0, bits_read}, 8'd0);
        strobe = 1'b0;
        tick(5);

        // 4: n_in rising together with strobe rising -> load only
        read_pulse();
        read_pulse();
        check("t4_pre_bits", {4'd0, bits_read}, 8'd2);
        n_in = 1'b0;
        tick(4);
        buttons = 8'b0000_0010;
        strobe  = 1'b1;
        n_in    = 1'b1;
        tick(4);
        strobe = 1'b0;
        tick(5);
        check("t4_bits_zero", {4'd0, bits_read}, 8'd0);
        check("t4_a_bit", {7'd0, ser_n}, 8'd1);
        read_pulse();
        check("t4_b_bit", {7'd0, ser_n}, 8'd0);
        check("t4_bits_one", {4'd0, bits_read}, 8'd1);

        // 6: async reset mid-report after 3 shifts
        buttons = 8'b0000_1001;
        load_pulse();
        read_pulse();
        read_pulse();
        read_pulse();
        check("t6_pre_ser_n", {7'd0, ser_n}, 8'd0);
        check("t6_pre_bits", {4'd0, bits_read}, 8'd3);
        #1;
        n_res = 1'b0;
        #1;
        check("t6_async_ser_n", {7'd0, ser_n}, 8'd1);
        check("t6_async_bits", {4'd0, bits_read}, 8'd0);
        tick(2);
        n_res = 1'b1;
        tick(5);
        check("t6_no_spurious_shift", {4'd0, bits_read}, 8'd0);
        check("t6_ser_n_idle", {7'd0, ser_n}, 8'd1);

        // 5: turbo on A; phase starts from reset above, 3 priming frames first
        turbo_en = 2'b01;
        buttons  = 8'h01;
        for (int f = 0; f < 3; f++) begin
            load_pulse();
            read_pulse();
        end
        for (int f = 0; f < 8; f++) begin
            load_pulse();
            check($sformatf("t5_frame%0d", f), {7'd0, ~ser_n}, {7'd0, exp_turbo[f]});
            read_pulse();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
